ysyx_22041752_ifu: RTL

//  Instruction fetch unit: upstream producer of the 32-bit instruction word

---
 rtl/ysyx_22041752_ifu.sv | 112 +++++++++++
 1 files changed

// File: rtl/ysyx_22041752_ifu.sv
// Instruction fetch unit: holds the PC, keeps at most one fetch in flight, and
// buffers returned words with their PCs in a small FIFO toward decode.
module ysyx_22041752_ifu #(
  parameter logic [63:0] RESET_PC   = 64'h8000_0000,
  parameter int unsigned IBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [63:0] inst_pc_o,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i
);

  localparam int unsigned PtrW = $clog2(IBUF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {SReq, SWait} state_e;

  state_e          state_q;
  logic [63:0]     pc_q;
  logic [63:0]     req_pc_q;
  logic            kill_q;
  logic [31:0]     inst_mem_q [IBUF_DEPTH];
  logic [63:0]     pc_mem_q   [IBUF_DEPTH];
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [CntW-1:0] count_q;

  logic req_fire;
  logic push;
  logic pop;

  // Only request when the FIFO can hold the response, so push never meets full.
  assign mem_req_valid = (state_q == SReq) && (count_q < CntW'(IBUF_DEPTH));
  assign mem_req_addr  = pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // Responses for killed requests and those landing on a redirect are dropped.
  assign push = (state_q == SWait) && mem_resp_valid && !kill_q && !redirect_i;

  assign inst_valid_o = (count_q != '0);
  assign pop          = inst_valid_o && inst_ready_i && !redirect_i;
  assign inst_o       = inst_mem_q[rd_ptr_q];
  assign inst_pc_o    = pc_mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SReq;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      kill_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(IBUF_DEPTH); i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      unique case (state_q)
        SReq: begin
          if (req_fire) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + 64'd4;
            state_q  <= SWait;
          end
        end
        SWait: begin
          if (mem_resp_valid) begin
            kill_q  <= 1'b0;
            state_q <= SReq;
          end
        end
        default: state_q <= SReq;
      endcase

      if (push) begin
        inst_mem_q[wr_ptr_q] <= mem_resp_data;
        pc_mem_q[wr_ptr_q]   <= req_pc_q;
        wr_ptr_q             <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end

      // Redirect overrides the PC update and FIFO bookkeeping above.
      if (redirect_i) begin
        pc_q     <= redirect_pc_i & ~64'h3;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
        if (req_fire || ((state_q == SWait) && !mem_resp_valid)) begin
          kill_q <= 1'b1;
        end
      end
    end
  end

endmodule
